// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU requester front end.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 8;

  // ALU operation encodings as seen on ALU_Sel
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3
  } op_e;

  // Select value that parks the ALU in its default/no-op behaviour
  localparam logic [OP_W-1:0] ALU_SEL_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // A command may reach the ALU only if the opcode exists and it is not a divide by zero
  function automatic logic is_legal(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] b);
    return (op <= OP_DIV) && !((op == OP_DIV) && (b == 8'd0));
  endfunction

endpackage

// File: rtl/alu_requester.sv
// Command/response front end that sequences one operation at a time through the registered ALU.
module alu_requester
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      ops_done,
  output logic [7:0]       err_cnt
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ALU_LATENCY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [3:0]       op_q;
  logic             cmd_ready_q;
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [3:0]       alu_sel_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_carry_q;
  logic             rsp_err_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [15:0]      ops_done_q;
  logic [7:0]       err_cnt_q;

  // Control FSM: accept, drive ALU, wait out its latency, hold the response until taken
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      op_q        <= ALU_SEL_IDLE;
      cmd_ready_q <= 1'b0;
      alu_a_q     <= 8'd0;
      alu_b_q     <= 8'd0;
      alu_sel_q   <= ALU_SEL_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
      ops_done_q  <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op;
            rsp_tag_q   <= cmd_tag;
            cmd_ready_q <= 1'b0;
            if (is_legal(cmd_op, cmd_b)) begin
              alu_a_q   <= cmd_a;
              alu_b_q   <= cmd_b;
              alu_sel_q <= cmd_op;
              state_q   <= ST_ISSUE;
            end else begin
              // Illegal: answer immediately, ALU stays parked
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 8'd0;
              rsp_carry_q <= 1'b0;
              rsp_err_q   <= 1'b1;
              state_q     <= ST_RESP;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        ST_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_out;
            rsp_carry_q <= (op_q == OP_ADD) && alu_carry;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= 8'd0;
            alu_b_q     <= 8'd0;
            alu_sel_q   <= ALU_SEL_IDLE;
            state_q     <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            ops_done_q  <= ops_done_q + 16'd1;
            if (rsp_err_q && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tag   = rsp_tag_q;
  assign ops_done  = ops_done_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_requester.sv
// Scoreboard bench for alu_requester driving a behavioural registered ALU.
module tb_alu_requester;

  localparam int unsigned LAT = 1;
  localparam int unsigned TW  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = 4'd0;
  logic [7:0]    cmd_a = 8'd0;
  logic [7:0]    cmd_b = 8'd0;
  logic [TW-1:0] cmd_tag = '0;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_sel;
  logic [7:0]    alu_out = 8'd0;
  logic          alu_carry = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_data;
  logic          rsp_carry;
  logic          rsp_err;
  logic [TW-1:0] rsp_tag;
  logic [15:0]   ops_done;
  logic [7:0]    err_cnt;

  typedef struct {
    int data;
    bit carry;
    bit err;
    int tag;
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_ops  = 0;
  int   exp_err  = 0;
  bit   prev_v   = 1'b0;
  int   win_lo   = 1;
  int   win_hi   = 0;
  int   exp_a    = 0;
  int   exp_b    = 0;
  int   exp_sel  = 0;
  bit   chk_int  = 1'b0;
  int   last_acc = -1;
  int   rr_mode  = 1;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  alu_requester #(.ALU_LATENCY(LAT), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .ops_done(ops_done), .err_cnt(err_cnt)
  );

  // Behavioural registered ALU with one cycle of output latency
  always @(posedge clock) begin
    if (reset) begin
      alu_out   <= 8'd0;
      alu_carry <= 1'b0;
    end else begin
      case (alu_sel)
        4'd0: begin alu_out <= alu_a + alu_b; alu_carry <= (int'(alu_a) + int'(alu_b)) > 255; end
        4'd1: begin alu_out <= alu_a - alu_b; alu_carry <= alu_a < alu_b; end
        4'd2: begin alu_out <= 8'(int'(alu_a) * int'(alu_b)); alu_carry <= (int'(alu_a) * int'(alu_b)) > 255; end
        4'd3: begin alu_out <= (alu_b == 8'd0) ? 8'd0 : alu_a / alu_b; alu_carry <= 1'b0; end
        default: begin alu_out <= 8'd0; alu_carry <= 1'b0; end
      endcase
    end
  end

  // Consumer back-pressure: 0 = stall, 1 = always ready, 2 = random
  always @(negedge clock) begin
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: what the requester should answer for a command
  function automatic exp_t model(input int op, input int a, input int b, input int tag);
    exp_t e;
    e.tag = tag; e.carry = 1'b0; e.err = 1'b0; e.data = 0; e.acc = 0;
    e.lat = int'(LAT) + 2;
    if (op > 3 || (op == 3 && b == 0)) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      case (op)
        0: begin e.data = (a + b) % 256; e.carry = (a + b) >= 256; end
        1: e.data = (a - b + 256) % 256;
        2: e.data = (a * b) % 256;
        default: e.data = a / b;
      endcase
    end
    return e;
  endfunction

  // Present a command, wait for the handshake, log expectations
  task automatic send(input int op, input int a, input int b, input int tag);
    exp_t e;
    int   n = 0;
    cmd_valid = 1'b1;
    cmd_op = 4'(op); cmd_a = 8'(a); cmd_b = 8'(b); cmd_tag = TW'(tag);
    while (!cmd_ready) begin
      @(negedge clock);
      n++;
      if (n > 300) begin
        chk("cmd_accept_timeout", 0, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    e = model(op, a, b, tag);
    e.acc = cyc;
    sb.push_back(e);
    if (!e.err) begin
      win_lo = cyc + 1; win_hi = cyc + 1 + int'(LAT);
      exp_a = a; exp_b = b; exp_sel = op;
    end
    if (chk_int && last_acc >= 0) chk("issue_interval", cyc - last_acc, int'(LAT) + 3);
    last_acc = cyc;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_tag = TW'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: per-cycle interface checks and response scoreboard
  always begin
    @(negedge clock);
    #1;
    if (reset) begin
      sb.delete();
      exp_ops = 0;
      exp_err = 0;
      prev_v  = 1'b0;
    end else begin
      chk("ops_done", int'(ops_done), exp_ops);
      chk("err_cnt", int'(err_cnt), exp_err);
      if (cyc >= win_lo && cyc <= win_hi) begin
        chk("alu_a_hold", int'(alu_a), exp_a);
        chk("alu_b_hold", int'(alu_b), exp_b);
        chk("alu_sel_hold", int'(alu_sel), exp_sel);
      end else begin
        chk("alu_sel_idle", int'(alu_sel), 15);
        chk("alu_a_idle", int'(alu_a), 0);
        chk("alu_b_idle", int'(alu_b), 0);
      end
      if (rsp_valid) begin
        chk("cmd_ready_busy", int'(cmd_ready), 0);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          if (!prev_v) chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
          chk("rsp_data", int'(rsp_data), sb[0].data);
          chk("rsp_carry", int'(rsp_carry), int'(sb[0].carry));
          chk("rsp_err", int'(rsp_err), int'(sb[0].err));
          chk("rsp_tag", int'(rsp_tag), sb[0].tag);
          if (rsp_ready) begin
            if (sb[0].err && exp_err < 255) exp_err++;
            exp_ops = (exp_ops + 1) % 65536;
            void'(sb.pop_front());
          end
        end
      end
      prev_v = rsp_valid && !rsp_ready;
    end
  end

  initial begin
    int n;
    int op;
    int b;
    rr_mode = 1;
    repeat (3) @(negedge clock);
    #2;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_alu_sel", int'(alu_sel), 15);
    chk("rst_ops_done", int'(ops_done), 0);
    chk("rst_rsp_tag", int'(rsp_tag), 0);
    reset = 1'b0;
    @(negedge clock);

    // Directed arithmetic and illegal commands
    send(0, 200, 100, 3);
    send(1, 5, 10, 1);
    send(2, 16, 20, 2);
    send(3, 100, 7, 4);
    send(3, 100, 0, 5);
    send(7, 1, 1, 6);
    drain();
    chk("ops_done_directed", int'(ops_done), 6);
    chk("err_cnt_directed", int'(err_cnt), 2);

    // Back-pressure: response held for 5 cycles
    rr_mode = 0;
    @(negedge clock);
    send(0, 1, 2, 9);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
    chk("bp_rsp_seen", int'(rsp_valid), 1);
    repeat (5) @(negedge clock);
    chk("bp_still_valid", int'(rsp_valid), 1);
    chk("bp_data_held", int'(rsp_data), 3);
    rr_mode = 1;
    drain();

    // Reset in the middle of WAIT drops the command
    rr_mode = 1;
    send(0, 50, 60, 11);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_ops_done", int'(ops_done), 0);
    chk("mid_rst_err_cnt", int'(err_cnt), 0);
    chk("mid_rst_alu_sel", int'(alu_sel), 15);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 0);
    @(negedge clock);
    send(0, 7, 8, 12);
    drain();

    // Back-to-back random ADDs at full throughput
    chk_int = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 300; i++) send(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i % 16);
    chk_int = 1'b0;
    drain();
    chk("ops_done_b2b", int'(ops_done), 301);

    // Random mixed traffic with random back-pressure
    rr_mode = 2;
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 5));
      b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      send(op, int'($urandom_range(0, 255)), b, int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    rr_mode = 1;
    drain();

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) send(int'($urandom_range(4, 15)), 1, 1, i % 16);
      else            send(3, int'($urandom_range(0, 255)), 0, i % 16);
    end
    drain();
    chk("err_cnt_saturated", int'(err_cnt), 255);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
